// File: rtl/joseproc_jose_proc_oci_dct_packer.sv
// joseproc_jose_proc_oci_dct_packer
//
// Purpose:
//   Collects 2-bit direct-control-transfer (DCT) codes from the CPU retire
//   path and packs them into 30-bit frames of up to 15 codes (newest code in
//   bits [1:0]). Frames leave under a valid/ready handshake. The block also
//   sequences end-of-test: end_req flushes any partial frame, and
//   test_has_ended rises once every frame has been delivered.
//
// Ports:
//   clk            in   1   single clock, rising-edge
//   reset          in   1   asynchronous, active-high reset
//   trace_en       in   1   1 = accept DCT events, 0 = ignore dct_valid
//   dct_valid      in   1   DCT event strobe
//   dct_code       in   2   00 no-op, 01 sequential, 10 direct taken, 11 indirect
//   end_req        in   1   single-cycle request to end the test
//   frame_ready    in   1   downstream accepts the frame this cycle
//   frame_valid    out  1   dct_buffer/dct_count hold a frame
//   dct_buffer     out  30  packed codes, unused upper bits 0
//   dct_count      out  4   number of codes in the frame (1..15)
//   test_ending    out  1   flush in progress or done (sticky)
//   test_has_ended out  1   all frames delivered after end_req (sticky)
//   overflow       out  1   sticky: an event was dropped
//   ovf_count      out  8   dropped-event count
//
// Configuration macro:
//   JOSEPROC_DCT_OVF_COUNT_EN - when defined, ovf_count counts dropped events
//   (saturating at 255); otherwise ovf_count is tied to zero.

module joseproc_jose_proc_oci_dct_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        trace_en,
  input  logic        dct_valid,
  input  logic [1:0]  dct_code,
  input  logic        end_req,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_ending,
  output logic        test_has_ended,
  output logic        overflow,
  output logic [7:0]  ovf_count
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FLUSH   = 2'd1,
    ENDED   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [29:0] acc;
  logic [3:0]  acc_cnt;
  logic        pend;

  logic [29:0] ins_acc;
  logic [3:0]  ins_cnt;
  logic        ins_pend;
  logic        accept;
  logic        full;
  logic        slot_free;
  logic        xfer;
  logic        restart;
  logic        drop;

  // Accumulator view after this cycle's event is inserted. The transfer
  // decision looks at this post-insert view so a closing event can leave in
  // its own cycle. An event arriving on a full accumulator is never inserted:
  // it either restarts the accumulator behind a transfer or is dropped.
  always_comb begin
    accept    = (state == COLLECT) && trace_en && dct_valid && (dct_code != 2'b00);
    full      = (acc_cnt == 4'd15);
    slot_free = !frame_valid || frame_ready;
    ins_acc   = acc;
    ins_cnt   = acc_cnt;
    ins_pend  = pend;
    if (accept && !full) begin
      ins_acc  = {acc[27:0], dct_code};
      ins_cnt  = acc_cnt + 4'd1;
      ins_pend = pend || (ins_cnt == 4'd15) || (dct_code == 2'b11);
    end
    xfer    = (ins_pend || ((state == FLUSH) && (ins_cnt != 4'd0))) && slot_free;
    restart = accept && full && xfer;
    drop    = accept && full && !xfer;
  end

  // Next-state logic: FLUSH ends only once the accumulator is empty and the
  // output slot has been taken by downstream. ENDED is terminal.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (end_req) state_next = FLUSH;
      FLUSH:   if ((acc_cnt == 4'd0) && !frame_valid) state_next = ENDED;
      ENDED:   state_next = ENDED;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= state_next;
  end

  // Accumulator and output frame register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= 30'd0;
      acc_cnt     <= 4'd0;
      pend        <= 1'b0;
      frame_valid <= 1'b0;
      dct_buffer  <= 30'd0;
      dct_count   <= 4'd0;
    end else begin
      if (xfer) begin
        dct_buffer  <= ins_acc;
        dct_count   <= ins_cnt;
        frame_valid <= 1'b1;
        if (restart) begin
          acc     <= {28'd0, dct_code};
          acc_cnt <= 4'd1;
          pend    <= (dct_code == 2'b11);
        end else begin
          acc     <= 30'd0;
          acc_cnt <= 4'd0;
          pend    <= 1'b0;
        end
      end else begin
        acc     <= ins_acc;
        acc_cnt <= ins_cnt;
        pend    <= ins_pend;
        if (frame_ready) frame_valid <= 1'b0;
      end
    end
  end

  // Sticky status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      if ((state == COLLECT) && end_req)             test_ending    <= 1'b1;
      if ((state == FLUSH) && (state_next == ENDED)) test_has_ended <= 1'b1;
      if (drop)                                      overflow       <= 1'b1;
    end
  end

`ifdef JOSEPROC_DCT_OVF_COUNT_EN
  // Dropped-event counter, saturating so it never wraps back to a small value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_count <= 8'd0;
    end else if (drop && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end
`else
  assign ovf_count = 8'd0;
`endif

endmodule
